fifo_sync_r: RTL and testbench
==============================

Name: fifo_sync_r

Overview:
- Parametrised single-clock FIFO built from resettable register storage (DFF-with-reset style), WIDTH x DEPTH.
- Registered read data, per-request acknowledge/error strobes, occupancy count.
- Default general-purpose buffer between producer/consumer blocks in the FIFO subsystem.

Parameters:
- WIDTH, 32, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock, rising-edge.
- reset_n  input  1  asynchronous active-low reset.
- wr_en  input  1  write request, sampled at rising edge.
- rd_en  input  1  read request, sampled at rising edge.
- d_in  input  WIDTH  write data.
- d_out  output  WIDTH  registered read data.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- wr_ack  output  1  one-cycle pulse: previous-edge write accepted.
- wr_err  output  1  one-cycle pulse: previous-edge write rejected (full).
- rd_ack  output  1  one-cycle pulse: previous-edge read accepted.
- rd_err  output  1  one-cycle pulse: previous-edge read rejected (empty).
- data_count  output  AW+1  current occupancy, 0..DEPTH.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, reset_n).
- Reset (reset_n=0, asynchronous, any time incl. mid-transfer): wr_ptr=0, rd_ptr=0, data_count=0, d_out=0, all storage words=0, wr_ack=wr_err=rd_ack=rd_err=0. Outputs: empty=1, full=0. Pending requests discarded.
- full/empty decoded combinationally from registered data_count only.
- Let W = wr_en and (not full or rd_en); R = rd_en and not empty. Evaluated on pre-edge state.
- On write accept: mem[wr_ptr] <= d_in; wr_ptr <= wr_ptr+1, wraps DEPTH-1 -> 0 (natural AW-bit wrap).
- On read accept: d_out <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, same wrap. Latency: data visible immediately after the accepting edge, same cycle as rd_ack.
- Rejected read: d_out holds its previous value. Rejected write: storage and wr_ptr unchanged.
- Count: +1 on W only, -1 on R only, unchanged on both or neither.
- Simultaneous wr_en and rd_en:
  - Not empty, not full: both accepted, count unchanged.
  - Full: read accepted AND write accepted (slot freed same edge), count stays DEPTH, wr_ack=1, rd_ack=1.
  - Empty: write accepted, read rejected (rd_err=1), count -> 1. No write-through bypass.
- Strobes: registered. wr_ack = W, wr_err = wr_en and not W, rd_ack = R, rd_err = rd_en and not R. All four are 0 on any edge without the corresponding request.
- No internal FSM beyond the pointer/count registers; state is fully defined by (wr_ptr, rd_ptr, data_count).
- Invariant: data_count == (wr_ptr - rd_ptr) mod DEPTH, except data_count==DEPTH when pointers are equal and the FIFO is full.

Optional Feature:
- Macro FIFO_SYNC_ALMOST_EN.
- Defined: adds parameters AF_LEVEL (default DEPTH-1) and AE_LEVEL (default 1), plus outputs almost_full (1 bit, data_count >= AF_LEVEL) and almost_empty (1 bit, data_count <= AE_LEVEL). Both are combinational from data_count. Reset values: almost_full=0, almost_empty=1.
- Undefined: these ports and parameters do not exist. All other behaviour is identical.

Test Plan (WIDTH=32, DEPTH=8, 20 ns clock period):
- Reset release, then idle 3 cycles -> empty=1, full=0, data_count=0, d_out=0, all strobes 0.
- Write 0x11..0x88 on 8 consecutive cycles -> wr_ack=1 each, data_count steps 1..8, full=1 after 8th. 9th write 0x99 -> wr_err=1, count stays 8.
- Read 9 consecutive cycles -> d_out 0x11,0x22,...,0x88 with rd_ack=1; 9th gives rd_err=1, d_out holds 0x88, empty=1.
- Pointer wrap: write 5 / read 5, then write 6 / read 6 -> read data matches write order across the 7->0 boundary, count returns to 0.
- Simultaneous requests: at count=0, wr+rd -> wr_ack=1, rd_err=1, count=1. At count=8, wr+rd -> both acks, count=8, oldest word out. At count=3, wr+rd -> count=3.
- Assert reset_n low asynchronously mid-burst at count=5 -> outputs return to reset values without waiting for a clock edge. After release, first read gives rd_err=1. With FIFO_SYNC_ALMOST_EN: almost_full=1 at count 7, almost_empty=1 at count <=1.

Source files
------------

// File: rtl/fifo_sync_r.sv
// Single-clock FIFO with resettable register storage, registered read data and request strobes.
// Define FIFO_SYNC_ALMOST_EN to add the almost_full/almost_empty outputs and their level parameters.
module fifo_sync_r #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8,
`ifdef FIFO_SYNC_ALMOST_EN
  parameter int AF_LEVEL = DEPTH - 1,
  parameter int AE_LEVEL = 1,
`endif
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH-1:0] d_out,
  output logic             full,
  output logic             empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err,
`ifdef FIFO_SYNC_ALMOST_EN
  output logic             almost_full,
  output logic             almost_empty,
`endif
  output logic [AW:0]      data_count
);

  localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic [WIDTH-1:0] r_dout;
  logic             r_wr_ack;
  logic             r_wr_err;
  logic             r_rd_ack;
  logic             r_rd_err;

  logic             w_full;
  logic             w_empty;
  logic             w_wr_acc;
  logic             w_rd_acc;

  assign w_full  = (r_count == C_DEPTH);
  assign w_empty = (r_count == '0);

  // A write into a full FIFO is still taken when a read frees the oldest slot on the same edge.
  assign w_wr_acc = wr_en & (~w_full | rd_en);
  assign w_rd_acc = rd_en & ~w_empty;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_dout   <= '0;
      r_wr_ack <= 1'b0;
      r_wr_err <= 1'b0;
      r_rd_ack <= 1'b0;
      r_rd_err <= 1'b0;
    end else begin
      r_wr_ack <= w_wr_acc;
      r_wr_err <= wr_en & ~w_wr_acc;
      r_rd_ack <= w_rd_acc;
      r_rd_err <= rd_en & ~w_rd_acc;
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_dout   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (AW + 1)'(1);
        2'b01:   r_count <= r_count - (AW + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage words clear on reset; a full-FIFO read returns the old word before it is overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= d_in;
    end
  end

  assign d_out      = r_dout;
  assign full       = w_full;
  assign empty      = w_empty;
  assign wr_ack     = r_wr_ack;
  assign wr_err     = r_wr_err;
  assign rd_ack     = r_rd_ack;
  assign rd_err     = r_rd_err;
  assign data_count = r_count;

`ifdef FIFO_SYNC_ALMOST_EN
  localparam logic [AW:0] C_AF = (AW + 1)'(AF_LEVEL);
  localparam logic [AW:0] C_AE = (AW + 1)'(AE_LEVEL);

  assign almost_full  = (r_count >= C_AF);
  assign almost_empty = (r_count <= C_AE);
`endif

endmodule

// File: tb/tb_fifo_sync_r.sv
// Randomized and directed bench for fifo_sync_r against a queue-based reference model.
module tb_fifo_sync_r;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] d_in;
  logic [WIDTH-1:0] d_out;
  logic             full;
  logic             empty;
  logic             wr_ack;
  logic             wr_err;
  logic             rd_ack;
  logic             rd_err;
  logic [AW:0]      data_count;
`ifdef FIFO_SYNC_ALMOST_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  fifo_sync_r #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .d_in         (d_in),
    .d_out        (d_out),
    .full         (full),
    .empty        (empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err),
`ifdef FIFO_SYNC_ALMOST_EN
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
`endif
    .data_count   (data_count)
  );

  always #10 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: FIFO contents as a queue plus the expected registered outputs.
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout;
  logic             m_wack, m_werr, m_rack, m_rerr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_wack = 1'b0;
    m_werr = 1'b0;
    m_rack = 1'b0;
    m_rerr = 1'b0;
  endtask

  task automatic model_step(input logic w, input logic r, input logic [WIDTH-1:0] d,
                            input logic rst_low);
    logic wa, ra, mfull, mempty;
    if (rst_low) begin
      model_reset();
      return;
    end
    mfull  = (m_q.size() == DEPTH);
    mempty = (m_q.size() == 0);
    wa = w && (!mfull || r);
    ra = r && !mempty;
    if (ra) m_dout = m_q.pop_front();
    if (wa) m_q.push_back(d);
    m_wack = wa;
    m_werr = w && !wa;
    m_rack = ra;
    m_rerr = r && !ra;
  endtask

  task automatic compare_all();
    check("d_out",      d_out,             m_dout);
    check("data_count", 32'(data_count),   32'(m_q.size()));
    check("full",       32'(full),         32'(m_q.size() == DEPTH));
    check("empty",      32'(empty),        32'(m_q.size() == 0));
    check("wr_ack",     32'(wr_ack),       32'(m_wack));
    check("wr_err",     32'(wr_err),       32'(m_werr));
    check("rd_ack",     32'(rd_ack),       32'(m_rack));
    check("rd_err",     32'(rd_err),       32'(m_rerr));
`ifdef FIFO_SYNC_ALMOST_EN
    check("almost_full",  32'(almost_full),  32'(m_q.size() >= DEPTH - 1));
    check("almost_empty", 32'(almost_empty), 32'(m_q.size() <= 1));
`endif
  endtask

  // Called at a falling edge: drive, take one rising edge, then compare 1 ns later.
  task automatic tick(input logic w, input logic r, input logic [WIDTH-1:0] d);
    logic rst_low;
    wr_en = w;
    rd_en = r;
    d_in  = d;
    @(posedge clk);
    rst_low = !reset_n;
    model_step(w, r, d, rst_low);
    #1;
    compare_all();
    @(negedge clk);
  endtask

  initial begin
    logic [WIDTH-1:0] v;
    int pw, pr;
    reset_n = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    d_in    = '0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_all();
    reset_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0, '0);
    check("idle_empty", 32'(empty),      32'd1);
    check("idle_full",  32'(full),       32'd0);
    check("idle_count", 32'(data_count), 32'd0);
    check("idle_dout",  d_out,           32'h0);

    // Fill to full, then one rejected write.
    for (int k = 1; k <= DEPTH; k++) begin
      tick(1'b1, 1'b0, 32'(k * 32'h11));
      check("fill_ack",   32'(wr_ack),     32'd1);
      check("fill_count", 32'(data_count), 32'(k));
`ifdef FIFO_SYNC_ALMOST_EN
      if (k == 7) check("af_at_7", 32'(almost_full), 32'd1);
`endif
    end
    check("fill_full", 32'(full), 32'd1);
    tick(1'b1, 1'b0, 32'h99);
    check("ovf_err",   32'(wr_err),     32'd1);
    check("ovf_count", 32'(data_count), 32'd8);

    // Drain in order, then one rejected read.
    for (int k = 1; k <= DEPTH; k++) begin
      tick(1'b0, 1'b1, '0);
      check("drain_data", d_out,         32'(k * 32'h11));
      check("drain_ack",  32'(rd_ack),   32'd1);
    end
    tick(1'b0, 1'b1, '0);
    check("udf_err",   32'(rd_err), 32'd1);
    check("udf_hold",  d_out,       32'h88);
    check("udf_empty", 32'(empty),  32'd1);

    // Pointer wrap across the last entry.
    repeat (5) begin v = $urandom; tick(1'b1, 1'b0, v); end
    repeat (5) tick(1'b0, 1'b1, '0);
    repeat (6) begin v = $urandom; tick(1'b1, 1'b0, v); end
    repeat (6) tick(1'b0, 1'b1, '0);
    check("wrap_count", 32'(data_count), 32'd0);

    // Simultaneous requests at empty, full and mid occupancy.
    tick(1'b1, 1'b1, 32'h100);
    check("sim0_wack",  32'(wr_ack),     32'd1);
    check("sim0_rerr",  32'(rd_err),     32'd1);
    check("sim0_count", 32'(data_count), 32'd1);
    for (int k = 1; k < DEPTH; k++) tick(1'b1, 1'b0, 32'(32'h100 + k));
    tick(1'b1, 1'b1, 32'h1AA);
    check("simF_wack",  32'(wr_ack),     32'd1);
    check("simF_rack",  32'(rd_ack),     32'd1);
    check("simF_count", 32'(data_count), 32'd8);
    check("simF_data",  d_out,           32'h100);
    repeat (5) tick(1'b0, 1'b1, '0);
    tick(1'b1, 1'b1, 32'h1BB);
    check("sim3_count", 32'(data_count), 32'd3);
    check("sim3_data",  d_out,           32'h106);

    // Randomized traffic with shifting write/read biases.
    for (int blk = 0; blk < 6; blk++) begin
      pw = $urandom_range(20, 80);
      pr = $urandom_range(20, 80);
      repeat (100) begin
        v = $urandom;
        tick(($urandom_range(0, 99) < pw), ($urandom_range(0, 99) < pr), v);
      end
    end

    // Bring occupancy to 5 and reset asynchronously between edges.
    for (int k = 0; k <= DEPTH && m_q.size() != 0; k++) tick(1'b0, 1'b1, '0);
    repeat (5) begin v = $urandom; tick(1'b1, 1'b0, v); end
    check("pre_rst_count", 32'(data_count), 32'd5);
    wr_en = 1'b1;
    d_in  = 32'hDEAD;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("arst_count", 32'(data_count), 32'd0);
    check("arst_empty", 32'(empty),      32'd1);
    @(negedge clk);
    repeat (2) tick(1'b1, 1'b0, 32'hBEEF);
    reset_n = 1'b1;
    tick(1'b0, 1'b1, '0);
    check("post_rst_rerr", 32'(rd_err), 32'd1);
    check("post_rst_dout", d_out,       32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
